// File: rtl/riscv_pkg.sv
// Types and constants shared by the fetch stage and the main decoder of the
// single-cycle RISC-V core.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // Instruction addresses must be word aligned (no compressed extension).
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential PC, branch target, the chosen
// next PC and its alignment check. All sums wrap modulo 2^XLEN.
module pc_next_calc
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm_ext,
  input  logic            i_pc_src,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_branch_tgt;
  logic [XLEN-1:0] w_pc_next;

  assign w_pc_plus4   = i_pc + PC_STEP;
  assign w_branch_tgt = i_pc + i_imm_ext;
  assign w_pc_next    = i_pc_src ? w_branch_tgt : w_pc_plus4;

  assign o_pc_plus4   = w_pc_plus4;
  assign o_pc_next    = w_pc_next;
  assign o_misaligned = is_misaligned(w_pc_next);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs one request/grant/response transaction at a
// time and hands instructions to the decoder over a valid/ready handshake.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0]     INSTRET_RESET = 32'h0000_0000
)(
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            pc_src,
  input  logic [XLEN-1:0] imm_ext,
  output logic            fetch_err,
  output logic [31:0]     instret
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_instr_valid;
  logic            r_fetch_err;
  logic [31:0]     r_instret;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  logic            w_misaligned;

  pc_next_calc u_pc_next_calc (
    .i_pc         (r_pc),
    .i_imm_ext    (imm_ext),
    .i_pc_src     (pc_src),
    .o_pc_plus4   (w_pc_plus4),
    .o_pc_next    (w_pc_next),
    .o_misaligned (w_misaligned)
  );

  // Fetch state machine with PC, instruction, error and retire-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_instret     <= INSTRET_RESET;
    end else begin
      case (r_state)
        FETCH: begin
          r_instr_valid <= 1'b0;
          if (imem_gnt) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            r_instret     <= r_instret + 32'd1;
            r_instr_valid <= 1'b0;
            // A misaligned target is never fetched; the PC keeps the faulting instruction.
            if (w_misaligned) begin
              r_fetch_err <= 1'b1;
              r_state     <= HALT;
            end else begin
              r_pc    <= w_pc_next;
              r_state <= FETCH;
            end
          end
        end
        HALT: begin
          r_instr_valid <= 1'b0;
          r_state       <= HALT;
        end
        default: begin
          r_instr_valid <= 1'b0;
          r_fetch_err   <= 1'b1;
          r_state       <= HALT;
        end
      endcase
    end
  end

  // The request must drop immediately while reset is held and rise in the first cycle after.
  assign imem_req    = (r_state == FETCH) & ~rst;
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign fetch_err   = r_fetch_err;
  assign instret     = r_instret;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: reactive memory with programmable latencies,
// directed consumer stimulus, a transaction-level model and per-cycle checks.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, pc_out, pc_plus4, imm_ext, instret;
  logic        instr_valid, instr_ready, pc_src, fetch_err;

  logic        w_req, w_valid, w_err;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_instret;

  int n_tests = 0;
  int n_fail  = 0;
  int gnt_dly = 0;
  int rv_dly  = 0;
  bit inject_rv = 1'b0;

  // Model: architectural state derived from the handshake rules only.
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0000_0013, m_instret = 32'h0;
  bit          m_valid = 1'b0, m_wait = 1'b0, m_halt = 1'b0, m_err = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .pc_src(pc_src), .imm_ext(imm_ext),
    .fetch_err(fetch_err), .instret(instret)
  );

  // Second copy starts its retire counter two short of wrapping.
  instr_fetch_unit #(.INSTRET_RESET(32'hFFFF_FFFE)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(w_instr), .instr_valid(w_valid), .instr_ready(instr_ready),
    .pc_out(w_pc), .pc_plus4(w_pc4), .pc_src(pc_src), .imm_ext(imm_ext),
    .fetch_err(w_err), .instret(w_instret)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[24:0], 7'b0010011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid_pc(input logic [31:0] pc);
    bit hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && pc_out === pc) hit = 1'b1;
    end
    chk("wait_valid_pc", 32'(hit), 32'd1);
  endtask

  initial begin : responder
    int cnt;
    bit busy;
    logic [31:0] addr;
    cnt = 0; busy = 1'b0; addr = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      if (rst) begin
        busy = 1'b0; cnt = 0;
      end else begin
        if (inject_rv) begin
          imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; inject_rv = 1'b0;
        end
        if (busy) begin
          if (cnt >= rv_dly) begin
            imem_rvalid = 1'b1; imem_rdata = mem_word(addr); busy = 1'b0; cnt = 0;
          end else cnt++;
        end else if (imem_req) begin
          if (cnt >= gnt_dly) begin
            imem_gnt = 1'b1; busy = 1'b1; addr = imem_addr; cnt = 0;
          end else cnt++;
        end
      end
    end
  end

  initial begin : model
    logic [31:0] nxt;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pc = 32'h0; m_instr = 32'h0000_0013; m_instret = 32'h0;
        m_valid = 1'b0; m_wait = 1'b0; m_halt = 1'b0; m_err = 1'b0;
      end else if (m_halt) begin
        m_valid = 1'b0;
      end else if (m_valid) begin
        if (instr_ready) begin
          nxt = pc_src ? m_pc + imm_ext : m_pc + 32'd4;
          m_instret = m_instret + 32'd1;
          m_valid = 1'b0;
          if (nxt[1:0] != 2'b00) begin
            m_err = 1'b1; m_halt = 1'b1;
          end else m_pc = nxt;
        end
      end else if (m_wait) begin
        if (imem_rvalid) begin
          m_instr = imem_rdata; m_valid = 1'b1; m_wait = 1'b0;
        end
      end else if (imem_gnt) begin
        m_wait = 1'b1;
      end
    end
  end

  initial begin : compare
    bit exp_req;
    forever begin
      @(negedge clk);
      exp_req = !rst && !m_halt && !m_valid && !m_wait;
      chk("imem_req",    32'(imem_req),    32'(exp_req));
      chk("imem_addr",   imem_addr,        m_pc);
      chk("pc_out",      pc_out,           m_pc);
      chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr",       instr,            m_instr);
      chk("fetch_err",   32'(fetch_err),   32'(m_err));
      chk("instret",     instret,          m_instret);
      chk("w_instret",   w_instret,        m_instret + 32'hFFFF_FFFE);
      chk("w_req",       32'(w_req),       32'(exp_req));
      chk("w_addr",      w_addr,           m_pc);
      chk("w_pc",        w_pc,             m_pc);
      chk("w_pc4",       w_pc4,            m_pc + 32'd4);
      chk("w_valid",     32'(w_valid),     32'(m_valid));
      chk("w_instr",     w_instr,          m_instr);
      chk("w_err",       32'(w_err),       32'(m_err));
    end
  end

  initial begin : stimulus
    rst = 1'b1; instr_ready = 1'b1; pc_src = 1'b0; imm_ext = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_pc",    pc_out,           32'h0000_0000);
    chk("lit_rst_instr", instr,            32'h0000_0013);
    chk("lit_rst_valid", 32'(instr_valid), 32'd0);
    chk("lit_rst_req",   32'(imem_req),    32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Zero-wait memory: three cycles per instruction.
    @(negedge clk);
    chk("lit_c0_req", 32'(imem_req), 32'd1);
    chk("lit_c0_addr", imem_addr, 32'h0);
    repeat (3) @(negedge clk);
    chk("lit_c3_req", 32'(imem_req), 32'd1);
    chk("lit_c3_addr", imem_addr, 32'h4);
    repeat (3) @(negedge clk);
    chk("lit_c6_req", 32'(imem_req), 32'd1);
    chk("lit_c6_addr", imem_addr, 32'h8);
    repeat (3) @(negedge clk);
    chk("lit_c9_instret", instret, 32'd3);

    // Backward branch 0x10 - 8 -> 0x08.
    wait_valid_pc(32'h10);
    pc_src = 1'b1; imm_ext = 32'hFFFF_FFF8;
    @(posedge clk); #1 pc_src = 1'b0; imm_ext = 32'h0;
    @(negedge clk);
    chk("lit_br_addr", imem_addr, 32'h8);
    chk("lit_br_req", 32'(imem_req), 32'd1);

    // Slow memory: grant after 4 idle cycles, response after 3 more.
    wait_valid_pc(32'h8);
    gnt_dly = 4; rv_dly = 3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lit_slow_req", 32'(imem_req), 32'd1);
      chk("lit_slow_addr", imem_addr, 32'hC);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_slow_wait_valid", 32'(instr_valid), 32'd0);
    end
    instr_ready = 1'b0;

    // Consumer stall: five VALID cycles without retire.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lit_stall_valid", 32'(instr_valid), 32'd1);
      chk("lit_stall_instr", instr, mem_word(32'hC));
      chk("lit_stall_pc", pc_out, 32'hC);
      chk("lit_stall_req", 32'(imem_req), 32'd0);
      chk("lit_stall_instret", instret, 32'd6);
    end
    instr_ready = 1'b1; gnt_dly = 0; rv_dly = 3;

    // Reset during WAIT, then a stray response right after release.
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; inject_rv = 1'b1;
    @(negedge clk);
    chk("lit_rrst_instr", instr, 32'h0000_0013);
    chk("lit_rrst_pc", pc_out, 32'h0);
    chk("lit_rrst_req", 32'(imem_req), 32'd1);
    rv_dly = 0;

    // Branch to the top of the address space, then sequential wrap to 0.
    wait_valid_pc(32'h0);
    pc_src = 1'b1; imm_ext = 32'hFFFF_FFFC;
    @(posedge clk); #1 pc_src = 1'b0; imm_ext = 32'h0;
    @(negedge clk);
    chk("lit_top_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid_pc(32'hFFFF_FFFC);
    @(negedge clk);
    chk("lit_wrap_addr", imem_addr, 32'h0);
    chk("lit_wrap_instret", instret, 32'd2);
    chk("lit_wrap_w_instret", w_instret, 32'h0);

    // Misaligned target halts the stage.
    wait_valid_pc(32'h0);
    pc_src = 1'b1; imm_ext = 32'h6;
    @(posedge clk); #1 pc_src = 1'b0; imm_ext = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lit_halt_err", 32'(fetch_err), 32'd1);
      chk("lit_halt_req", 32'(imem_req), 32'd0);
      chk("lit_halt_valid", 32'(instr_valid), 32'd0);
      chk("lit_halt_pc", pc_out, 32'h0);
      chk("lit_halt_instret", instret, 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that feeds the main decoder of the single-cycle RISC-V core. It owns the program counter, requests instruction words from instruction memory over a request/grant/response handshake, and presents one instruction at a time with a valid/ready handshake. When the current instruction retires, it uses the decoder's PCSrc and the extended immediate to select the next PC. It also flags misaligned branch targets and counts retired instructions.

## Interface
- XLEN, 32, datapath/address width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  XLEN  fetch address, always equals pc_out
- imem_gnt  in  1  memory accepted the request this cycle
- imem_rvalid  in  1  imem_rdata is valid this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  held instruction to decoder (op = instr[6:0])
- instr_valid  out  1  instr/pc_out are valid
- instr_ready  in  1  consumer retires instr this cycle
- pc_out  out  XLEN  PC of instr
- pc_plus4  out  XLEN  pc_out + 4, combinational
- pc_src  in  1  branch taken (Zero & Branch from decoder); sampled only at retire
- imm_ext  in  XLEN  sign-extended immediate; sampled only at retire
- fetch_err  out  1  sticky misaligned-target flag
- instret  out  32  retired-instruction counter

## Operation
- States: FETCH, WAIT, VALID, HALT. Reset state: FETCH.
- FETCH: imem_req=1, imem_addr=pc_out. When imem_gnt=1, go to WAIT. imem_rvalid is ignored in FETCH.
- WAIT: imem_req=0. When imem_rvalid=1, capture imem_rdata into instr and go to VALID.
- VALID: instr_valid=1. Retire = instr_valid & instr_ready. On retire:
  - next = pc_src ? pc_out + imm_ext : pc_out + 4, modulo 2^XLEN (wrap-around; no carry-out kept).
  - instret increments by 1 and wraps at 2^32.
  - If next[1:0] != 0: pc_out is unchanged, fetch_err is set to 1, go to HALT.
  - Otherwise: pc_out = next, go to FETCH.
- HALT: no requests, instr_valid=0. Leaves HALT only on rst.
- Without retire, VALID holds: instr and pc_out are stable and instr_valid stays 1.
- Only one memory transaction is outstanding at a time. Redirects happen only at retire, so no in-flight response is ever discarded.
- rst asserted mid-transaction (WAIT): the state machine returns to FETCH. A late imem_rvalid after reset release falls in FETCH and is ignored.

## Timing
- Reset values: pc_out=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0 while rst=1, fetch_err=0, instret=0, state FETCH.
- imem_req rises combinationally in the first cycle after rst deasserts.
- With zero-wait memory (gnt in the FETCH cycle, rvalid in the next cycle) and ready held at 1, there are 3 cycles per instruction: FETCH, WAIT, VALID.
- instr_valid rises exactly 1 cycle after the imem_rvalid cycle.
- The new pc_out is visible the cycle after retire.
- pc_src and imm_ext are combinational inputs derived from instr. They must be stable in the retire cycle; the block never registers them.

## Structure
- Shared package riscv_pkg holds:
  - XLEN
  - NOP_INSTR = 32'h0000_0013
  - the fetch_state_t enum {FETCH, WAIT, VALID, HALT}
  - opcode constants OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_RTYPE 7'b0110011, OP_BRANCH 7'b1100011 (used jointly with the main decoder)
- One sub-module: pc_next_calc, a combinational block producing pc_plus4, the branch target, the next PC and the misalign flag.
- The state machine, PC register, instruction register and counter live in instr_fetch_unit.

## Test plan
- Reset release, zero-wait memory, ready=1, pc_src=0 -> imem_addr sequence 0x0, 0x4, 0x8 at 3-cycle spacing; instret=3 after the third retire.
- Branch retire at pc=0x10 with pc_src=1, imm_ext=0xFFFFFFF8 -> next imem_addr=0x08; pc_src=1 with imm_ext=0x6 -> fetch_err=1, HALT, no further imem_req.
- gnt delayed 4 cycles and rvalid delayed 3 cycles -> imem_req and imem_addr held stable until gnt; instr captured exactly the rvalid word; instr_valid 1 cycle later.
- instr_ready held 0 for 5 cycles in VALID -> instr, pc_out and instr_valid stable throughout; no imem_req; instret unchanged.
- rst pulsed during WAIT, then spurious rvalid in the first post-reset cycle -> instr stays 0x00000013, pc_out=RESET_PC, new request issued to RESET_PC.
- pc=0xFFFFFFFC retire with pc_src=0 -> pc_out wraps to 0x00000000; instret preset near 0xFFFFFFFF wraps to 0.
